// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - CPU, debug and memory bus bundle for dmem_arbiter
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic [DATA_W-1:0] dbg_rdata;
  logic              dbg_ack;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_rdata, dbg_ack,
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_rdata, dbg_ack,
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU/debug data memory arbiter with starvation guard
// Optional conflict/forced-grant counters enabled by DMEM_ARB_STATS_EN.
module dmem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]   stat_conflicts,
  output logic [15:0]   stat_forced
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  state_t            state;
  logic [7:0]        wait_cnt;
  logic [DATA_W-1:0] rdata_q;
  logic              eligible;
  logic              grant;
  logic [ADDR_W-1:0] addr_mux;
  logic [DATA_W-1:0] wdata_mux;

  // ACK blocks a second grant so a still-held dbg_req cannot execute twice.
  always_comb begin
    eligible = bus.dbg_req && (state != ACK) && !rst;
    grant    = eligible && (!bus.cpu_req || (wait_cnt >= LIMIT));
  end

  assign addr_mux      = grant ? bus.dbg_addr : bus.cpu_addr;
  assign wdata_mux     = grant ? bus.dbg_wdata : bus.cpu_wdata;
  assign bus.mem_addr  = addr_mux;
  assign bus.mem_wdata = wdata_mux;
  assign bus.mem_we    = !rst && (grant ? bus.dbg_we : (bus.cpu_req && bus.cpu_we));
  assign bus.cpu_stall = bus.cpu_req && grant;
  assign bus.cpu_rdata = bus.mem_rdata;
  assign bus.dbg_rdata = rdata_q;
  assign bus.dbg_ack   = (state == ACK);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= 8'd0;
      rdata_q  <= '0;
    end else begin
      unique case (state)
        IDLE, WAIT: begin
          if (grant) begin
            state    <= ACK;
            wait_cnt <= 8'd0;
            rdata_q  <= bus.mem_rdata;
          end else if (bus.dbg_req) begin
            state    <= WAIT;
            wait_cnt <= (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;
          end else begin
            state    <= IDLE;
            wait_cnt <= 8'd0;
          end
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DMEM_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_conflicts <= 16'd0;
      stat_forced    <= 16'd0;
    end else begin
      if (bus.cpu_req && eligible && (stat_conflicts != 16'hFFFF))
        stat_conflicts <= stat_conflicts + 16'd1;
      if (bus.cpu_stall && (stat_forced != 16'hFFFF))
        stat_forced <= stat_forced + 16'd1;
    end
  end
`endif

endmodule
